sw_ctrl: RTL
============

Name: sw_ctrl

Overview:
- Sequencing controller for the Smith-Waterman systolic PE array.
- Accepts the serial reference/query base stream and shifts the query into the PE chain.
- Buffers the reference, then replays it into the array one base per cycle and waits out the wavefront drain.
- Tracks the best cell score reported by the array and presents max/pos_ref/pos_query with a one-cycle finish pulse.

Parameters:
- REF_LEN, 64, reference bases per job
- QUERY_LEN, 32, query bases per job (equals the PE count)
- WIDTH_SCORE, 8, score width
- WIDTH_POS_REF, 7, reference position width (1-based, 0 = none)
- WIDTH_POS_QUERY, 6, query position width (1-based, 0 = none)
- ARR_LAT, 1, array output latency in cycles

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- valid  in  1  input base qualifier
- data_ref  in  2  reference base
- data_query  in  2  query base, used for the first QUERY_LEN accepted cycles
- finish  out  1  one-cycle job-done pulse
- max  out  WIDTH_SCORE  best score
- pos_ref  out  WIDTH_POS_REF  reference position of best score
- pos_query  out  WIDTH_POS_QUERY  query position of best score
- arr_clear  out  1  one-cycle array score clear
- arr_load_q  out  1  shift arr_q_base into the PE query chain
- arr_q_base  out  2  query base being loaded
- arr_ref_valid  out  1  reference base entering PE0
- arr_ref_base  out  2  reference base
- arr_ref_idx  out  WIDTH_POS_REF  1-based index of arr_ref_base
- arr_cell_valid  in  1  array candidate valid (best of current wavefront, reduced in array)
- arr_cell_score  in  WIDTH_SCORE  candidate score
- arr_cell_ref  in  WIDTH_POS_REF  candidate reference position
- arr_cell_query  in  WIDTH_POS_QUERY  candidate query position

Behaviour:
- Reset (reset=0, async): FSM to IDLE; all outputs 0; counters and best-score registers 0; ref buffer contents don't-care.
- Accept rule: valid is sampled only in IDLE and LOAD. Each sampled cycle stores data_ref at ref_buf[cnt]. For cnt<QUERY_LEN it also drives arr_load_q=1 with arr_q_base=data_query combinationally in that cycle. cnt then increments.
- IDLE: valid=1 accepts base 0 and moves to LOAD.
- LOAD: a valid=0 gap holds cnt and outputs no load. Accepting base REF_LEN-1 moves to CLEAR.
- CLEAR: one cycle. arr_clear=1; best registers zeroed; max/pos outputs zero. Next state RUN.
- RUN: REF_LEN cycles. arr_ref_valid=1, arr_ref_base=ref_buf[i], arr_ref_idx=i+1 for i=0..REF_LEN-1. Next state DRAIN.
- DRAIN: QUERY_LEN+ARR_LAT cycles with arr_ref_valid=0. Next state DONE.
- DONE: one cycle. finish=1, and max/pos hold the final best. Next state IDLE.
- Output hold: max/pos hold the final best until the next CLEAR.
- Latency at defaults: finish is high in cycle 99 after the edge that sampled the last base, i.e. 1+REF_LEN+QUERY_LEN+ARR_LAT+1 cycles.
- Best-score tracking: arr_cell_valid is honoured only in RUN and DRAIN. Update when score>best.
- Tie-break: on score==best, take the smaller pos_ref; if pos_ref is also equal, take the smaller pos_query. Update takes effect at the next edge.
- All-zero candidates leave max=0, pos_ref=0, pos_query=0.
- valid in CLEAR/RUN/DRAIN/DONE is ignored and its data dropped. arr_cell_valid outside RUN/DRAIN is ignored.
- Reset asserted mid-job returns to IDLE; no finish is produced. After release, a fresh job proceeds normally.
- Counter widths: cnt and the RUN index use WIDTH_POS_REF bits. The DRAIN counter is sized for QUERY_LEN+ARR_LAT. None of them wrap within a job.

Optional Feature:
- Macro SW_CTRL_PROTOCOL_CHECK_EN.
- Defined: adds output proto_err (1 bit, sticky, reset 0).
  - Set when valid=1 in CLEAR/RUN/DRAIN/DONE.
  - Set when arr_cell_valid=1 outside RUN/DRAIN.
  - Cleared when IDLE accepts a new job.
- Undefined: port absent; these events are silently ignored as above.

Decomposition:
- Package sw_pkg:
  - state enum IDLE/LOAD/CLEAR/RUN/DRAIN/DONE
  - base encodings A=00, C=01, G=10, T=11
  - default REF_LEN, QUERY_LEN, ARR_LAT
  - derived DRAIN_CYC=QUERY_LEN+ARR_LAT
- Sub-module sw_max_tracker: compare, tie-break and best-score register, with clear and enable inputs.

Test Plan:
1. Reset check: hold reset=0 mid-clock -> all outputs 0 immediately; FSM IDLE.
2. Gapless 64-cycle job; array model reports a single candidate, score 10 at (5,3) -> max=10, pos_ref=5, pos_query=3; finish high exactly 99 cycles after the last-base edge; arr_load_q high for exactly 32 cycles.
3. valid low for 3 cycles after base 20 -> cnt holds, no arr_load_q in the gap, ref_buf order intact (arr_ref_base sequence matches input); finish 3 cycles later than in test 2.
4. Ties: candidates 12@(40,10), 12@(30,20), 12@(30,5), then 11@(1,1) -> max=12, pos_ref=30, pos_query=5.
5. Reset pulse during RUN cycle 10 -> arr_ref_valid drops immediately, no finish; a following job gives correct results.
6. All candidates score 0, plus valid=1 during RUN -> max=0, pos 0/0, finish normal; with SW_CTRL_PROTOCOL_CHECK_EN defined, proto_err=1 until the next job is accepted.

Source files
------------

// File: rtl/sw_ctrl_pkg.sv
// Shared types and default geometry for the Smith-Waterman sequencing controller.
package sw_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CLEAR = 3'd2,
      RUN   = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      BASE_A = 2'b00,
      BASE_C = 2'b01,
      BASE_G = 2'b10,
      BASE_T = 2'b11
   } base_t;

   localparam int REF_LEN_DEF   = 64;
   localparam int QUERY_LEN_DEF = 32;
   localparam int ARR_LAT_DEF   = 1;
   localparam int DRAIN_CYC_DEF = QUERY_LEN_DEF + ARR_LAT_DEF;

   // Bits needed for a counter that must hold the value n itself.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sw_ctrl_max_tracker.sv
// Best-cell register: keeps the highest score, ties resolved toward the smaller
// reference position and then the smaller query position.
module sw_max_tracker #(
   parameter int WS = 8,
   parameter int WR = 7,
   parameter int WQ = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          en,
   input  logic [WS-1:0] score,
   input  logic [WR-1:0] cand_ref,
   input  logic [WQ-1:0] cand_query,
   output logic [WS-1:0] best_score,
   output logic [WR-1:0] best_ref,
   output logic [WQ-1:0] best_query
);

   logic better;

   always_comb begin
      better = 1'b0;
      if (score > best_score)
         better = 1'b1;
      else if (score == best_score)
         better = (cand_ref < best_ref) ||
                  ((cand_ref == best_ref) && (cand_query < best_query));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         best_score <= '0;
         best_ref   <= '0;
         best_query <= '0;
      end else if (clear) begin
         best_score <= '0;
         best_ref   <= '0;
         best_query <= '0;
      end else if (en && better) begin
         best_score <= score;
         best_ref   <= cand_ref;
         best_query <= cand_query;
      end
   end

endmodule

// File: rtl/sw_ctrl.sv
// Sequencing controller for the Smith-Waterman systolic PE array.
// Optional sticky protocol-error output under SW_CTRL_PROTOCOL_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for the first base of a job
// LOAD  | buffering reference, shifting query into the PE chain
// CLEAR | one-cycle array/best-score clear
// RUN   | replaying the buffered reference, one base per cycle
// DRAIN | waiting out the wavefront through the array
// DONE  | one-cycle finish pulse, result valid
module sw_ctrl
   import sw_pkg::*;
#(
   parameter int REF_LEN         = REF_LEN_DEF,
   parameter int QUERY_LEN       = QUERY_LEN_DEF,
   parameter int WIDTH_SCORE     = 8,
   parameter int WIDTH_POS_REF   = 7,
   parameter int WIDTH_POS_QUERY = 6,
   parameter int ARR_LAT         = ARR_LAT_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid,
   input  logic [1:0]                 data_ref,
   input  logic [1:0]                 data_query,
   output logic                       finish,
   output logic [WIDTH_SCORE-1:0]     max,
   output logic [WIDTH_POS_REF-1:0]   pos_ref,
   output logic [WIDTH_POS_QUERY-1:0] pos_query,
   output logic                       arr_clear,
   output logic                       arr_load_q,
   output logic [1:0]                 arr_q_base,
   output logic                       arr_ref_valid,
   output logic [1:0]                 arr_ref_base,
   output logic [WIDTH_POS_REF-1:0]   arr_ref_idx,
   input  logic                       arr_cell_valid,
   input  logic [WIDTH_SCORE-1:0]     arr_cell_score,
   input  logic [WIDTH_POS_REF-1:0]   arr_cell_ref,
   input  logic [WIDTH_POS_QUERY-1:0] arr_cell_query
`ifdef SW_CTRL_PROTOCOL_CHECK_EN
   ,
   output logic                       proto_err
`endif
);

   localparam int DRAIN_CYC = QUERY_LEN + ARR_LAT;
   localparam int IDX_W     = $clog2(REF_LEN);
   localparam int DRN_W     = cnt_width(DRAIN_CYC);

   localparam logic [WIDTH_POS_REF-1:0] REF_LAST = WIDTH_POS_REF'(REF_LEN - 1);
   localparam logic [WIDTH_POS_REF-1:0] REF_END  = WIDTH_POS_REF'(REF_LEN);
   localparam logic [WIDTH_POS_REF-1:0] Q_END    = WIDTH_POS_REF'(QUERY_LEN);
   localparam logic [DRN_W-1:0]         DRN_TOP  = DRN_W'(DRAIN_CYC - 1);

   state_t                   state;
   logic [WIDTH_POS_REF-1:0] cnt;
   logic [DRN_W-1:0]         drain_cnt;
   logic [1:0]               ref_buf [REF_LEN];
   logic                     accept;
   logic                     last_base;
   logic                     trk_en;

   assign accept     = valid && ((state == IDLE) || (state == LOAD));
   assign last_base  = accept && (cnt == REF_LAST);
   assign arr_load_q = accept && (cnt < Q_END);
   assign arr_q_base = arr_load_q ? data_query : 2'b00;
   assign trk_en     = arr_cell_valid && ((state == RUN) || (state == DRAIN));

   // Buffer contents need no reset; they are always rewritten before RUN reads them.
   always_ff @(posedge clk) begin
      if (accept)
         ref_buf[cnt[IDX_W-1:0]] <= data_ref;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         drain_cnt     <= '0;
         arr_clear     <= 1'b0;
         arr_ref_valid <= 1'b0;
         arr_ref_base  <= 2'b00;
         arr_ref_idx   <= '0;
         finish        <= 1'b0;
      end else begin
         arr_clear <= 1'b0;
         finish    <= 1'b0;
         unique case (state)
            IDLE, LOAD: begin
               if (accept) begin
                  if (last_base) begin
                     state     <= CLEAR;
                     cnt       <= '0;
                     arr_clear <= 1'b1;
                  end else begin
                     state <= LOAD;
                     cnt   <= cnt + 1'b1;
                  end
               end
            end
            CLEAR: begin
               state         <= RUN;
               arr_ref_valid <= 1'b1;
               arr_ref_base  <= ref_buf[0];
               arr_ref_idx   <= WIDTH_POS_REF'(1);
            end
            RUN: begin
               if (arr_ref_idx == REF_END) begin
                  state         <= DRAIN;
                  arr_ref_valid <= 1'b0;
                  arr_ref_base  <= 2'b00;
                  arr_ref_idx   <= '0;
                  drain_cnt     <= DRN_TOP;
               end else begin
                  // arr_ref_idx is 1-based, so it already addresses the next base.
                  arr_ref_base <= ref_buf[arr_ref_idx[IDX_W-1:0]];
                  arr_ref_idx  <= arr_ref_idx + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state  <= DONE;
                  finish <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Clearing on the edge that enters CLEAR makes the outputs read zero during CLEAR.
   sw_max_tracker #(
      .WS (WIDTH_SCORE),
      .WR (WIDTH_POS_REF),
      .WQ (WIDTH_POS_QUERY)
   ) u_max (
      .clk        (clk),
      .reset      (reset),
      .clear      (last_base),
      .en         (trk_en),
      .score      (arr_cell_score),
      .cand_ref   (arr_cell_ref),
      .cand_query (arr_cell_query),
      .best_score (max),
      .best_ref   (pos_ref),
      .best_query (pos_query)
   );

`ifdef SW_CTRL_PROTOCOL_CHECK_EN
   logic perr_evt;

   assign perr_evt = (valid && ((state == CLEAR) || (state == RUN) ||
                                (state == DRAIN) || (state == DONE))) ||
                     (arr_cell_valid && !((state == RUN) || (state == DRAIN)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         proto_err <= 1'b0;
      else if (perr_evt)
         proto_err <= 1'b1;
      else if (accept && (state == IDLE))
         proto_err <= 1'b0;
   end
`endif

endmodule
